ramb_port_scheduler: RTL and testbench

Scheduler for the shared data RAM's second port, which serves two requesters: the ADC sample path (EMG/ECG ring-buffer writes) and the VGA trace reader (reads). It owns per-channel ring-buffer write indices and buffers samples in a small write FIFO. It arbitrates one port-B operation per cycle: VGA reads have priority, with bounded starvation of pending writes. It replaces the ad-hoc "sample strobe overrides VGA address" muxing in the top level, where VGA reads are silently corrupted on sample cycles.

---
 rtl/ramb_sched_pkg.sv | 23 ++
 rtl/ramb_port_scheduler_sync_fifo.sv | 51 +++++
 rtl/ramb_port_scheduler.sv | 132 +++++++++++++
 tb/tb_ramb_port_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ramb_sched_pkg.sv
// Shared constants and helpers for the port-B scheduler of the data RAM.
// Ring geometry, bus widths and channel encodings live here.
package ramb_sched_pkg;

    localparam int          ADDR_W       = 12;
    localparam int          DATA_W       = 32;
    localparam logic [11:0] EMG_BASE     = 12'hC7F;
    localparam logic [11:0] ECG_BASE     = 12'h801;
    localparam int          RING_LEN     = 640;
    localparam int          IDX_W        = 10;
    localparam int          FIFO_DEPTH   = 4;
    localparam int          STARVE_LIMIT = 8;

    localparam logic CH_EMG = 1'b0;
    localparam logic CH_ECG = 1'b1;

    // Ring index successor: len-1 wraps back to the first entry.
    function automatic logic [IDX_W-1:0] ring_next(input logic [IDX_W-1:0] idx,
                                                   input int               len);
        return (int'(idx) == len - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/ramb_port_scheduler_sync_fifo.sv
// Small synchronous FIFO (power-of-two depth) holding queued RAM writes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, and this keeps it mappable to LUT-RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/ramb_port_scheduler.sv
// Port-B scheduler for the shared data RAM: queues EMG/ECG ring writes and
// arbitrates them against VGA trace reads, with bounded write starvation.
module ramb_port_scheduler #(
    parameter int                ADDR_W       = ramb_sched_pkg::ADDR_W,
    parameter int                DATA_W       = ramb_sched_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] EMG_BASE     = ramb_sched_pkg::EMG_BASE,
    parameter logic [ADDR_W-1:0] ECG_BASE     = ramb_sched_pkg::ECG_BASE,
    parameter int                RING_LEN     = ramb_sched_pkg::RING_LEN,
    parameter int                FIFO_DEPTH   = ramb_sched_pkg::FIFO_DEPTH,
    parameter int                STARVE_LIMIT = ramb_sched_pkg::STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              smp_valid,
    input  logic              smp_chan,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [9:0]        emg_idx,
    output logic [9:0]        ecg_idx,
    output logic              overflow,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    import ramb_sched_pkg::CH_ECG;
    import ramb_sched_pkg::ring_next;

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_VGA_RD,
        ARB_WR,
        ARB_FORCE_WR
    } arb_e;

    entry_t            push_entry;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    arb_e              arb;
    logic [SC_W-1:0]   starve_cnt;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // A sample stalls while reset is high even though the FIFO is empty then.
    assign smp_ready = !fifo_full && !reset;
    assign push      = smp_valid && smp_ready;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        push_entry      = '0;
        push_entry.data = smp_data;
        if (smp_chan == CH_ECG) push_entry.addr = ECG_BASE + ADDR_W'(ecg_idx);
        else                    push_entry.addr = EMG_BASE + ADDR_W'(emg_idx);
    end

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Priority: starved write, then VGA read, then opportunistic write.
    always_comb begin
        arb = ARB_IDLE;
        if (reset) begin
            arb = ARB_IDLE;
        end else if (!fifo_empty && starve_cnt == SC_W'(STARVE_LIMIT)) begin
            arb = ARB_FORCE_WR;
        end else if (vga_req) begin
            arb = ARB_VGA_RD;
        end else if (!fifo_empty) begin
            arb = ARB_WR;
        end
    end

    assign ram_wen  = (arb == ARB_WR) || (arb == ARB_FORCE_WR);
    assign pop      = ram_wen;
    assign ram_addr = ram_wen ? head.addr : vga_addr;
    assign ram_din  = head.data;

    always_ff @(posedge clock) begin
        if (reset) begin
            emg_idx    <= '0;
            ecg_idx    <= '0;
            overflow   <= 1'b0;
            starve_cnt <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (push) begin
                if (smp_chan == CH_ECG) ecg_idx <= ring_next(ecg_idx, RING_LEN);
                else                    emg_idx <= ring_next(emg_idx, RING_LEN);
            end
            if (smp_valid && !smp_ready) overflow <= 1'b1;

            if (ram_wen || fifo_empty)   starve_cnt <= '0;
            else if (arb == ARB_VGA_RD)  starve_cnt <= starve_cnt + 1'b1;

            rvalid_q <= (arb == ARB_VGA_RD);
            if (rvalid_q) rdata_q <= ram_dout;
        end
    end

    // Read data arrives from the RAM one cycle after the grant; hold it afterwards.
    assign vga_rvalid = rvalid_q && !reset;
    assign vga_rdata  = vga_rvalid ? ram_dout : rdata_q;

endmodule

// File: tb/tb_ramb_port_scheduler.sv
// Self-checking bench for ramb_port_scheduler: directed stimulus pushes expected
// RAM writes and read returns into queues, a monitor pops and compares them.
module tb_ramb_port_scheduler;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rst_drv;
    logic        smp_valid;
    logic        smp_chan;
    logic [31:0] smp_data;
    logic        smp_ready;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic [9:0]  emg_idx;
    logic [9:0]  ecg_idx;
    logic        overflow;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int          n_tests = 0;
    int          n_fail  = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];

    logic [31:0] mem [4096];
    bit [4095:0] wr_mark;

    always #14 clock = ~clock;

    ramb_port_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .smp_valid  (smp_valid),
        .smp_chan   (smp_chan),
        .smp_data   (smp_data),
        .smp_ready  (smp_ready),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .emg_idx    (emg_idx),
        .ecg_idx    (ecg_idx),
        .overflow   (overflow),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Background contents of never-written words.
    function automatic logic [31:0] pat(input logic [11:0] a);
        return {16'hA5A5, 4'h0, a};
    endfunction

    // Port-B RAM with 1-cycle synchronous read.
    always @(posedge clock) begin
        if (ram_wen) begin
            mem[ram_addr]     <= ram_din;
            wr_mark[ram_addr] <= 1'b1;
        end
        ram_dout <= wr_mark[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write and every read return must match the queue head.
    always @(negedge clock) begin
        wr_t e;
        if (ram_wen === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, none expected",
                         ram_addr, ram_din);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_din, e.data);
            end
        end
        if (vga_rvalid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: data=0x%0h, none expected", vga_rdata);
            end else begin
                check("rd_data", vga_rdata, exp_rd.pop_front());
            end
        end
    end

    // One cycle of stimulus; acc/wa = expected accepted write, gnt = expected read grant.
    task automatic tick(input logic v, input logic ch, input logic [31:0] d,
                        input bit acc, input logic [11:0] wa,
                        input logic req, input logic [11:0] a, input bit gnt);
        @(posedge clock);
        #1;
        reset     = rst_drv;
        smp_valid = v;
        smp_chan  = ch;
        smp_data  = d;
        vga_req   = req;
        vga_addr  = a;
        if (acc) exp_wr.push_back({wa, d});
        if (gnt) exp_rd.push_back((a == 12'h900) ? 32'h55 : pat(a));
        @(negedge clock);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_drv   = 1'b1;
        reset     = 1'b1;
        smp_valid = 1'b0;
        smp_chan  = 1'b0;
        smp_data  = '0;
        vga_req   = 1'b0;
        vga_addr  = '0;

        // Reset: port quiet, input stalled even with a sample and a read pending.
        repeat (3) begin
            tick(1'b1, 1'b0, 32'h77, 1'b0, 12'h0, 1'b1, 12'h050, 1'b0);
            check("rst_ready", smp_ready, 0);
            check("rst_wen", ram_wen, 0);
        end
        rst_drv = 1'b0;
        idle();
        check("rst_rvalid", vga_rvalid, 0);
        check("rst_rdata", vga_rdata, 0);
        check("rst_emg_idx", emg_idx, 0);
        check("rst_ecg_idx", ecg_idx, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready_after", smp_ready, 1);

        // Single EMG sample, written the next cycle at the ring base.
        tick(1'b1, 1'b0, 32'hABCD, 1'b1, 12'hC7F, 1'b0, 12'h0, 1'b0);
        idle();
        check("emg_first_wen", ram_wen, 1);
        check("emg_first_addr", ram_addr, 12'hC7F);
        check("emg_first_din", ram_din, 32'hABCD);
        check("emg_idx_1", emg_idx, 1);

        // 641 ECG samples: index wraps after 640, sample 255 lands at 0x900.
        for (int k = 0; k <= 640; k++) begin
            tick(1'b1, 1'b1, (k == 255) ? 32'h55 : 32'hEC00_0000 + k,
                 1'b1, (k == 640) ? 12'h801 : 12'(12'h801 + k),
                 1'b0, 12'h0, 1'b0);
            if (k == 640) begin
                check("ecg_last_addr", ram_addr, 12'hA80);
                check("ecg_idx_wrap", ecg_idx, 0);
            end
        end
        idle();
        check("ecg_wrap_addr", ram_addr, 12'h801);
        check("ecg_idx_after_wrap", ecg_idx, 1);

        // Read back the word written by ECG sample 255.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, 12'h900, 1'b1);
        idle();
        check("rd900_rvalid", vga_rvalid, 1);
        check("rd900_rdata", vga_rdata, 32'h55);
        idle();
        check("rd900_rvalid_drop", vga_rvalid, 0);
        check("rd900_rdata_hold", vga_rdata, 32'h55);

        // Starvation: 8 read grants, then a forced write steals the 9th cycle.
        tick(1'b1, 1'b0, 32'h1111, 1'b1, 12'hC80, 1'b1, 12'h100, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, 12'(12'h100 + i), 1'b1);
            check("starve_no_wr", ram_wen, 0);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, 12'h109, 1'b0);
        check("force_wen", ram_wen, 1);
        check("force_addr", ram_addr, 12'hC80);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, 12'h10A, 1'b1);
        check("force_no_rvalid", vga_rvalid, 0);
        idle();
        check("resume_rvalid", vga_rvalid, 1);

        // Overflow: 4 samples fill the FIFO under reads, the 5th is dropped.
        tick(1'b1, 1'b0, 32'hA1, 1'b1, 12'hC81, 1'b1, 12'h110, 1'b1);
        tick(1'b1, 1'b1, 32'hB2, 1'b1, 12'h802, 1'b1, 12'h111, 1'b1);
        tick(1'b1, 1'b0, 32'hC3, 1'b1, 12'hC82, 1'b1, 12'h112, 1'b1);
        tick(1'b1, 1'b1, 32'hD4, 1'b1, 12'h803, 1'b1, 12'h113, 1'b1);
        tick(1'b1, 1'b0, 32'hE5, 1'b0, 12'h0,   1'b1, 12'h114, 1'b1);
        check("full_ready", smp_ready, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, 12'h115, 1'b1);
        check("overflow_set", overflow, 1);
        check("drop_emg_idx", emg_idx, 4);
        check("drop_ecg_idx", ecg_idx, 3);
        // Pop and push in the same cycle while full: still no bypass.
        tick(1'b1, 1'b0, 32'hF6, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
        check("nobypass_ready", smp_ready, 0);
        check("nobypass_wen", ram_wen, 1);
        idle();
        check("nobypass_emg_idx", emg_idx, 4);
        repeat (3) idle();
        check("drain_ready", smp_ready, 1);
        check("overflow_sticky", overflow, 1);

        // Reset with 3 entries queued behind reads: all discarded.
        tick(1'b1, 1'b0, 32'h31, 1'b0, 12'h0, 1'b1, 12'h120, 1'b1);
        tick(1'b1, 1'b1, 32'h32, 1'b0, 12'h0, 1'b1, 12'h121, 1'b1);
        tick(1'b1, 1'b0, 32'h33, 1'b0, 12'h0, 1'b1, 12'h122, 1'b0);
        rst_drv = 1'b1;
        tick(1'b1, 1'b0, 32'h34, 1'b0, 12'h0, 1'b1, 12'h123, 1'b0);
        check("midrst_wen", ram_wen, 0);
        check("midrst_rvalid", vga_rvalid, 0);
        check("midrst_ready", smp_ready, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
        rst_drv = 1'b0;
        idle();
        check("postrst_ready", smp_ready, 1);
        check("postrst_emg_idx", emg_idx, 0);
        check("postrst_ecg_idx", ecg_idx, 0);
        check("postrst_overflow", overflow, 0);
        repeat (3) begin
            idle();
            check("postrst_no_wr", ram_wen, 0);
        end

        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
